// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle fetch/execute core: opcodes, IR
// field positions, FSM state encoding and flag bit indices.
package cpu_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;
  localparam logic [4:0] OP_JMP     = 5'd12;
  localparam logic [4:0] OP_JZ      = 5'd13;
  localparam logic [4:0] OP_JNZ     = 5'd14;
  localparam logic [4:0] OP_HALT    = 5'd15;

  localparam int OPER_LO  = 27;
  localparam int RDST_LO  = 22;
  localparam int RSRC1_LO = 17;
  localparam int IMM_BIT  = 16;
  localparam int RSRC2_LO = 11;
  localparam int ISRC_LO  = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int FLAG_SIGN  = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_CARRY = 0;

  // Opcodes 0..11 produce a result and update the flags.
  function automatic logic is_alu_op(input logic [4:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath: result, new SGPR value and {sign,zero,ovf,carry}
// for the ALU opcodes. Non-ALU opcodes produce don't-care outputs.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        oper,
  input  logic              imm_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] sgpr,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] sgpr_next,
  output logic [3:0]        flags
);

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;
  logic                carry;
  logic                ovf;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    prod      = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    result    = '0;
    sgpr_next = sgpr;
    carry     = 1'b0;
    ovf       = 1'b0;
    case (oper)
      OP_MOVSGPR: result = sgpr;
      OP_MOV:     result = imm_mode ? b : a;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        // diff[DATA_W] is the borrow, i.e. a < b unsigned.
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_MUL: begin
        result    = prod[DATA_W-1:0];
        sgpr_next = prod[2*DATA_W-1:DATA_W];
      end
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_NOT:  result = imm_mode ? ~b : ~a;
      default: result = '0;
    endcase

    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
    if (oper == OP_MUL) begin
      flags[FLAG_SIGN] = prod[2*DATA_W-1];
      flags[FLAG_ZERO] = (prod == '0);
    end else begin
      flags[FLAG_SIGN] = result[DATA_W-1];
      flags[FLAG_ZERO] = (result == '0);
    end
  end

endmodule

// File: rtl/cpu_fsm_core.sv
// Multi-cycle core: IDLE -> FETCH (req/valid handshake) -> EXEC -> FETCH,
// with PC sequencing, conditional jumps and an absorbing HALT state.
module cpu_fsm_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              halted,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam logic [5:0] NREG_L = 6'(NREG);

  state_t              state_q, state_d;
  logic [31:0]         ir_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   gpr [NREG];
  logic [DATA_W-1:0]   sgpr_q;
  logic [3:0]          flags_q;

  logic [4:0]          oper, rdst, rsrc1, rsrc2;
  logic                imm_mode;
  logic [DATA_W-1:0]   isrc_ext, a_val, b_val;
  logic [DATA_W-1:0]   alu_result, alu_sgpr;
  logic [3:0]          alu_flags;
  logic [ADDR_W-1:0]   pc_inc, jmp_target;

  assign oper       = ir_q[OPER_LO +: 5];
  assign rdst       = ir_q[RDST_LO +: 5];
  assign rsrc1      = ir_q[RSRC1_LO +: 5];
  assign rsrc2      = ir_q[RSRC2_LO +: 5];
  assign imm_mode   = ir_q[IMM_BIT];
  assign isrc_ext   = DATA_W'(ir_q[ISRC_LO +: 16]);
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign jmp_target = ir_q[ISRC_LO +: ADDR_W];

  // Indices beyond the implemented register count read as zero.
  assign a_val     = ({1'b0, rsrc1} < NREG_L) ? gpr[rsrc1] : '0;
  assign b_val     = imm_mode ? isrc_ext :
                     (({1'b0, rsrc2} < NREG_L) ? gpr[rsrc2] : '0);
  assign dbg_rdata = ({1'b0, dbg_raddr} < NREG_L) ? gpr[dbg_raddr] : '0;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .oper      (oper),
    .imm_mode  (imm_mode),
    .a         (a_val),
    .b         (b_val),
    .sgpr      (sgpr_q),
    .result    (alu_result),
    .sgpr_next (alu_sgpr),
    .flags     (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_valid) state_d = S_EXEC;
      S_EXEC:  state_d = (oper == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with rst drops the request in the same cycle reset is raised.
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign halted    = (state_q == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      sgpr_q  <= '0;
      flags_q <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_valid) ir_q <= imem_rdata;
      if (state_q == S_EXEC) begin
        if (is_alu_op(oper)) begin
          if ({1'b0, rdst} < NREG_L) gpr[rdst] <= alu_result;
          if (oper == OP_MUL) sgpr_q <= alu_sgpr;
          flags_q <= alu_flags;
        end
        case (oper)
          OP_JMP:  pc_q <= jmp_target;
          OP_JZ:   pc_q <= flags_q[FLAG_ZERO] ? jmp_target : pc_inc;
          OP_JNZ:  pc_q <= flags_q[FLAG_ZERO] ? pc_inc : jmp_target;
          OP_HALT: pc_q <= pc_q;
          default: pc_q <= pc_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_fsm_core.sv
// Directed programs against an instruction-level reference model, with a
// per-cycle compare process and literal end-of-program expectations.
module tb_cpu_fsm_core;

  localparam int DW = 16;
  localparam int AW = 11;
  localparam logic [31:0] NOP = 32'hF800_0000;

  logic          clk;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_valid;
  logic [AW-1:0] pc;
  logic [3:0]    flags;
  logic          halted;
  logic [4:0]    dbg_raddr;
  logic [DW-1:0] dbg_rdata;

  cpu_fsm_core #(.DATA_W(DW), .NREG(32), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc         (pc),
    .flags      (flags),
    .halted     (halted),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory + responder ----------------
  logic [31:0] mem [2048];
  int lat = 0;
  int wcnt = 0;

  function automatic logic [31:0] ii(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = NOP;
  endtask

  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req) begin
        if (wcnt >= lat) begin
          imem_valid = 1'b1;
          imem_rdata = mem[imem_addr];
        end else begin
          imem_valid = 1'b0;
        end
        wcnt++;
      end else begin
        imem_valid = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg [32];
  logic [DW-1:0] m_sgpr;
  logic [3:0]    m_flags;
  logic [AW-1:0] m_pc;
  logic          m_halted;
  logic [31:0]   m_ir;
  logic          exec_pending;
  logic          compare_en;
  logic          prev_req;
  logic [AW-1:0] prev_addr;
  int            hs_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_sgpr = '0; m_flags = '0; m_pc = '0; m_halted = 1'b0; m_ir = '0;
  endtask

  task automatic model_exec(input logic [31:0] ir);
    logic [4:0]  op, rd, rs1, rs2;
    logic        imm;
    logic [15:0] isrc, a, b, res;
    int unsigned ua, ub;
    int          sa, sb, s;
    longint unsigned p;
    logic        alu, c, v, sg, z;
    op = ir[31:27]; rd = ir[26:22]; rs1 = ir[21:17]; imm = ir[16];
    rs2 = ir[15:11]; isrc = ir[15:0];
    a = m_reg[rs1];
    b = imm ? isrc : m_reg[rs2];
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    res = '0; c = 0; v = 0; alu = (op <= 5'd11); p = 0;
    case (op)
      5'd0:  res = m_sgpr;
      5'd1:  res = imm ? isrc : a;
      5'd2: begin
        res = 16'(ua + ub); c = (ua + ub) > 65535;
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      5'd3: begin
        res = 16'(ua - ub); c = ua < ub;
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      5'd4: begin
        p = longint'(ua) * longint'(ub);
        res = p[15:0];
      end
      5'd5:  res = a | b;
      5'd6:  res = a & b;
      5'd7:  res = a ^ b;
      5'd8:  res = ~(a ^ b);
      5'd9:  res = ~(a & b);
      5'd10: res = ~(a | b);
      5'd11: res = imm ? ~b : ~a;
      default: res = '0;
    endcase
    if (op == 5'd4) begin sg = p[31]; z = (p == 0); end
    else begin sg = res[15]; z = (res == 0); end
    // Branch decisions use the flags from before this instruction.
    case (op)
      5'd12: m_pc = isrc[AW-1:0];
      5'd13: m_pc = m_flags[2] ? isrc[AW-1:0] : m_pc + 11'd1;
      5'd14: m_pc = m_flags[2] ? m_pc + 11'd1 : isrc[AW-1:0];
      5'd15: m_halted = 1'b1;
      default: m_pc = m_pc + 11'd1;
    endcase
    if (alu) begin
      m_reg[rd] = res;
      if (op == 5'd4) m_sgpr = p[31:16];
      m_flags = {sg, z, v, c};
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [4:0] next_raddr;
    exec_pending = 0; prev_req = 0; prev_addr = '0; hs_cnt = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        exec_pending = 0; prev_req = 0; hs_cnt = 0;
      end else if (compare_en) begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("flags", 32'(flags), 32'(m_flags));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(m_reg[dbg_raddr]));
        if (exec_pending || m_halted) chk("imem_req_low", 32'(imem_req), 32'd0);
        if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        if (prev_req && imem_req) chk("addr_stable", 32'(imem_addr), 32'(prev_addr));
        prev_req   = imem_req && !imem_valid;
        prev_addr  = imem_addr;
        next_raddr = dbg_raddr + 5'd1;
        if (exec_pending) begin
          model_exec(m_ir);
          exec_pending = 0;
          next_raddr = m_ir[26:22];
        end
        if (imem_req && imem_valid) begin
          m_ir = imem_rdata;
          exec_pending = 1;
          hs_cnt++;
        end
        dbg_raddr = next_raddr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_prog(input int l);
    lat = l;
    @(negedge clk);
    rst = 1'b0;
    compare_en = 1'b1;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_halt_reached"}, 32'(halted), 32'd1);
    @(negedge clk);
    #1 compare_en = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [4:0] idx, input logic [DW-1:0] exp);
    dbg_raddr = idx;
    #1 chk(name, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic do_reset();
    compare_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; compare_en = 1'b0; dbg_raddr = '0;
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk_reg("rst_r0", 5'd0, 16'h0000);

    // basic program, valid one cycle after req
    mem[0] = ii(5'd1, 5'd1, 5'd0, 16'h000F);
    mem[1] = ii(5'd1, 5'd2, 5'd0, 16'h00FF);
    mem[2] = rr(5'd2, 5'd3, 5'd1, 5'd2);
    mem[3] = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    run_prog(1);
    @(posedge clk); #1 chk("first_req", 32'(imem_req), 32'd1);
    wait_halt("p1", 200);
    chk_reg("p1_r3", 5'd3, 16'h010E);
    chk("p1_flags", 32'(flags), 32'h0);
    chk("p1_pc", 32'(pc), 32'd3);
    chk("p1_req", 32'(imem_req), 32'd0);

    // signed/unsigned overflow on add
    do_reset(); clear_mem();
    mem[0] = ii(5'd1, 5'd0, 5'd0, 16'h8000);
    mem[1] = ii(5'd1, 5'd1, 5'd0, 16'h8002);
    mem[2] = rr(5'd2, 5'd2, 5'd0, 5'd1);
    mem[3] = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    run_prog(0);
    wait_halt("p2", 200);
    chk_reg("p2_r2", 5'd2, 16'h0002);
    chk("p2_flags", 32'(flags), 32'b0011);

    // multiply with high half through SGPR
    do_reset(); clear_mem();
    mem[0] = ii(5'd1, 5'd1, 5'd0, 16'h1234);
    mem[1] = ii(5'd4, 5'd4, 5'd1, 16'h0100);
    mem[2] = rr(5'd0, 5'd5, 5'd0, 5'd0);
    mem[3] = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    run_prog(2);
    wait_halt("p3", 300);
    chk_reg("p3_r4", 5'd4, 16'h3400);
    chk_reg("p3_r5", 5'd5, 16'h0012);

    // borrow, then jz not taken, jnz taken
    do_reset(); clear_mem();
    mem[0] = ii(5'd3, 5'd6, 5'd0, 16'h0001);
    mem[1] = ii(5'd13, 5'd0, 5'd0, 16'h0007);
    mem[2] = ii(5'd14, 5'd0, 5'd0, 16'h0005);
    mem[5] = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    mem[7] = ii(5'd1, 5'd7, 5'd0, 16'h0BAD);
    mem[8] = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    run_prog(0);
    wait_halt("p4", 200);
    chk_reg("p4_r6", 5'd6, 16'hFFFF);
    chk("p4_flags", 32'(flags), 32'b1001);
    chk("p4_pc", 32'(pc), 32'd5);
    chk_reg("p4_r7", 5'd7, 16'h0000);

    // PC wrap 2047 -> 0 with 5-cycle fetch stalls
    do_reset(); clear_mem();
    mem[0]    = ii(5'd14, 5'd0, 5'd0, 16'd2045);
    mem[1]    = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    mem[2045] = ii(5'd1, 5'd1, 5'd0, 16'h0000);
    run_prog(5);
    wait_halt("p5", 400);
    chk("p5_pc", 32'(pc), 32'd1);
    chk("p5_flags", 32'(flags), 32'b0100);

    // reset in the middle of a stalled fetch
    do_reset(); clear_mem();
    mem[0] = ii(5'd1, 5'd1, 5'd0, 16'h000F);
    mem[1] = ii(5'd1, 5'd2, 5'd0, 16'h00FF);
    mem[2] = rr(5'd2, 5'd3, 5'd1, 5'd2);
    mem[3] = ii(5'd15, 5'd0, 5'd0, 16'h0000);
    run_prog(8);
    begin
      int cyc = 0;
      while ((hs_cnt < 2 || !imem_req) && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("p6_stall_reached", 32'(hs_cnt >= 2 && imem_req), 32'd1);
    end
    repeat (2) @(negedge clk);
    #1 compare_en = 1'b0;
    chk_reg("p6_r1_before", 5'd1, 16'h000F);
    rst = 1'b1;
    #1;
    chk("p6_rst_req", 32'(imem_req), 32'd0);
    chk("p6_rst_pc", 32'(pc), 32'd0);
    chk("p6_rst_flags", 32'(flags), 32'd0);
    for (int i = 0; i < 32; i++) chk_reg("p6_rst_dbg", 5'(i), 16'h0000);
    @(posedge clk); #1;
    run_prog(0);
    wait_halt("p6_restart", 200);
    chk_reg("p6_r3", 5'd3, 16'h010E);
    chk("p6_pc", 32'(pc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt + 1);
    $fatal(1, "watchdog");
  end

endmodule
